// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Ports:
//   CLK, Reset          clock, synchronous active-high reset
//   Start, MDOp         request pulse and operation select (sampled only when idle)
//   ReadData1/2         operands (A: multiplicand/dividend/MTHI-MTLO source, B: multiplier/divisor)
//   Busy, Done, DivZero status: busy while computing, one-cycle done / divide-by-zero pulses
//   HI, LO              result registers
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned AW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    acc_q;      // mult: {hi,lo} accumulator; div: {rem,quot}
    logic [WIDTH-1:0] b_q;        // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] a_orig_q;   // raw dividend, returned in HI on divide-by-zero
    logic             is_div_q;
    logic             res_neg_q;
    logic             rem_neg_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;
    logic             divzero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             is_signed_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [AW-1:0]    mul_next_c;
    logic [WIDTH+1:0] div_diff_c;
    logic [AW-1:0]    div_next_c;
    logic [AW-1:0]    prod_fix_c;

    // Operand magnitudes and signs for the signed ops
    always_comb begin
        is_signed_c = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        a_neg_c     = is_signed_c & ReadData1[WIDTH-1];
        b_neg_c     = is_signed_c & ReadData2[WIDTH-1];
        a_mag_c     = a_neg_c ? WIDTH'(-ReadData1) : ReadData1;
        b_mag_c     = b_neg_c ? WIDTH'(-ReadData2) : ReadData2;
    end

    // One shift-add multiply step: add into the upper half with carry, then shift right
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : (WIDTH+1)'(0));
        mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};
    end

    // One restoring divide step; the shifted remainder keeps its carry-out bit
    always_comb begin
        div_diff_c = {1'b0, acc_q[AW-1:WIDTH-1]} - {2'b00, b_q};
        if (!div_diff_c[WIDTH+1]) begin
            div_next_c = {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next_c = {acc_q[AW-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix_c = res_neg_q ? AW'(-acc_q) : acc_q;
    end

    // Control FSM and datapath registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            a_orig_q  <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            OP_MTHI: hi_q <= ReadData1;
                            OP_MTLO: lo_q <= ReadData1;
                            OP_MULT, OP_MULTU: begin
                                acc_q     <= {WIDTH'(0), b_mag_c};
                                b_q       <= a_mag_c;
                                is_div_q  <= 1'b0;
                                res_neg_q <= a_neg_c ^ b_neg_c;
                                rem_neg_q <= 1'b0;
                                dz_q      <= 1'b0;
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= S_CALC;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc_q     <= {WIDTH'(0), a_mag_c};
                                b_q       <= b_mag_c;
                                a_orig_q  <= ReadData1;
                                is_div_q  <= 1'b1;
                                res_neg_q <= a_neg_c ^ b_neg_c;
                                rem_neg_q <= a_neg_c;
                                dz_q      <= (ReadData2 == '0);
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= S_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    acc_q <= is_div_q ? div_next_c : mul_next_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_q && dz_q) begin
                        hi_q <= a_orig_q;
                        lo_q <= '1;
                    end else if (is_div_q) begin
                        hi_q <= rem_neg_q ? WIDTH'(-acc_q[AW-1:WIDTH]) : acc_q[AW-1:WIDTH];
                        lo_q <= res_neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                    end else begin
                        hi_q <= prod_fix_c[AW-1:WIDTH];
                        lo_q <= prod_fix_c[WIDTH-1:0];
                    end
                    divzero_q <= is_div_q & dz_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (directed table, corner sequences,
// randomized ops against an arithmetic reference model).
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(clk), .Reset(rst), .Start(start), .MDOp(mdop),
        .ReadData1(rd1), .ReadData2(rd2),
        .Busy(busy), .Done(done), .DivZero(divzero), .HI(hi), .LO(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Arithmetic reference: plain 64-bit math on the architectural definition
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            OP_MULT: begin
                p  = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'b0, a} * {32'b0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    ed = 1'b1;
                    eh = a;
                    el = 32'hFFFFFFFF;
                end else if (o == OP_DIV) begin
                    p  = 64'(sa / sb);
                    el = p[31:0];
                    p  = 64'(sa % sb);
                    eh = p[31:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Present a request for one cycle, then scramble the operand inputs
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        mdop  = o;
        rd1   = a;
        rd2   = b;
        @(negedge clk);
        start = 1'b0;
        mdop  = 3'($urandom_range(7, 0));
        rd1   = $urandom;
        rd2   = $urandom;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        int bad;
        bad = 0;
        issue(o, a, b);
        for (int i = 0; i < 33; i++) begin
            if (!(busy === 1'b1 && done === 1'b0 && divzero === 1'b0)) bad++;
            @(negedge clk);
        end
        chk({name, ".latency"}, 64'(bad), 64'd0);
        chk({name, ".done"}, 64'({busy, done, divzero}), 64'({1'b0, 1'b1, edz}));
        chk({name, ".hi"}, 64'(hi), 64'(ehi));
        chk({name, ".lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        chk({name, ".pulse_end"}, 64'({done, divzero}), 64'd0);
    endtask

    initial begin
        int          c;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1'b0};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[6] = '{OP_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[9] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        mdop  = 3'b111;
        rd1   = '0;
        rd2   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.flags", 64'({busy, done, divzero}), 64'd0);
        chk("reset.hilo", {hi, lo}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        // MTLO writes LO in the cycle after acceptance without going busy
        issue(OP_MTLO, 32'h1234, 32'd0);
        chk("mtlo", 64'({busy, done, lo}), 64'({1'b0, 1'b0, 32'h1234}));

        // A Start while busy (MTHI) must be dropped
        issue(OP_MULT, 32'd2, 32'd3);
        repeat (5) @(negedge clk);
        start = 1'b1;
        mdop  = OP_MTHI;
        rd1   = 32'hAAAA;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start.busy", 64'(busy), 64'd1);
        wait_done(60, c);
        chk("busy_start.cycles", 64'(c), 64'd27);
        chk("busy_start.hilo", {hi, lo}, {32'd0, 32'd6});

        // Start during the Done cycle is accepted
        issue(OP_MULTU, 32'd5, 32'd6);
        wait_done(60, c);
        chk("b2b.first_cycles", 64'(c), 64'd33);
        chk("b2b.first_hilo", {hi, lo}, {32'd0, 32'd30});
        start = 1'b1;
        mdop  = OP_DIVU;
        rd1   = 32'd100;
        rd2   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        rd1   = $urandom;
        rd2   = $urandom;
        chk("b2b.accept", 64'({busy, done}), 64'({1'b1, 1'b0}));
        wait_done(60, c);
        chk("b2b.second_cycles", 64'(c), 64'd33);
        chk("b2b.second_hilo", {hi, lo}, {32'd2, 32'd14});
        @(negedge clk);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(3, 0));
            a = $urandom;
            case ($urandom_range(7, 0))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(15, 1));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(7, 0) == 0) a = 32'h80000000;
            model(o, a, b, eh, el, ed);
            run_md($sformatf("rand%0d_op%0d_%h_%h", i, o, a, b), o, a, b, eh, el, ed);
        end

        // Reset in the middle of a divide clears everything, no Done follows
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset.flags", 64'({busy, done, divzero}), 64'd0);
        chk("midreset.hilo", {hi, lo}, 64'd0);
        wait_done(45, c);
        chk("midreset.no_done", 64'(c), 64'd45);
        run_md("midreset.multu", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
